vscpu_mem_responder: RTL and testbench

Memory-side responder for the VSCPU RAM interface. Single-port word memory that answers the CPU's address/write-enable/data bus with one-cycle registered read latency. Adds a host loader port that streams a program image into memory and a dump port that streams a memory region back out. While either transfer runs, the CPU is frozen through `cpu_hold`. Sits between the CPU core and the top-level/testbench host.

---
 rtl/vscpu_mem_responder.sv | 194 +++++++++++++++++++
 tb/tb_vscpu_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscpu_mem_responder.sv
// vscpu_mem_responder
//   Memory-side responder for the VSCPU RAM bus. Single-port word memory with
//   a one-cycle registered CPU read, plus a host loader (stream in) and a dump
//   port (stream out). While a transfer runs the CPU is frozen via cpu_hold.
//
//   Optional feature macro: VSCPU_MEM_PARITY_EN
//     defined   -> each word carries an even-parity bit; CPU reads and dump
//                  reads recheck it and set the sticky parity_err flag.
//     undefined -> no parity storage, parity_err tied low.
//
//   Handshakes (valid/ready): a word moves on a rising edge where both valid
//   and ready are high. The loader offers load_valid and we answer with
//   load_ready; the dump side raises dump_valid, holds dump_data stable and
//   never drops dump_valid until the host answers with dump_ready (or rst).
//
//   Address arithmetic (base + cnt) truncates to ADDR_LEN bits, so it wraps
//   modulo DEPTH for the default DEPTH = 2**ADDR_LEN.
//
//   dbg_state exposes the FSM state: 0 IDLE, 1 LOAD, 2 DUMP_RD, 3 DUMP_OUT.

module vscpu_mem_responder #(
  parameter int ADDR_LEN = 14,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2**ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  // CPU port
  input  logic [ADDR_LEN-1:0] cpu_addr,
  input  logic                cpu_wrEn,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_hold,
  // transfer setup
  input  logic [ADDR_LEN-1:0] xfer_base,
  input  logic [ADDR_LEN:0]   xfer_len,
  // loader
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [DATA_W-1:0]   load_data,
  output logic                load_ready,
  // dump
  input  logic                dump_start,
  output logic                dump_valid,
  output logic [DATA_W-1:0]   dump_data,
  input  logic                dump_ready,
  // status
  output logic                busy,
  output logic                parity_err,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_DUMP_RD  = 2'd2;
  localparam logic [1:0] ST_DUMP_OUT = 2'd3;

  localparam logic [ADDR_LEN:0] CNT_ONE = {{ADDR_LEN{1'b0}}, 1'b1};

`ifdef VSCPU_MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [MW-1:0]       mem [0:DEPTH-1];

  logic [1:0]          r_state;
  logic [ADDR_LEN:0]   r_cnt;
  logic [ADDR_LEN-1:0] r_base;
  logic [ADDR_LEN:0]   r_len;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dump_data;

  logic                w_idle;
  logic                w_start_ok;
  logic                w_last;
  logic [ADDR_LEN-1:0] w_xfer_addr;
  logic                w_we;
  logic [ADDR_LEN-1:0] w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [MW-1:0]       w_wword;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_start_ok  = (xfer_len != '0);
  assign w_last      = (r_cnt == (r_len - CNT_ONE));
  assign w_xfer_addr = r_base + r_cnt[ADDR_LEN-1:0];

  // One write port shared by the CPU (IDLE) and the loader (LOAD).
  // Writes are suppressed while rst is high so a reset never lands a word.
  assign w_we    = !rst && ((w_idle && cpu_wrEn) ||
                            ((r_state == ST_LOAD) && load_valid));
  assign w_waddr = w_idle ? cpu_addr  : w_xfer_addr;
  assign w_wdata = w_idle ? cpu_wdata : load_data;

`ifdef VSCPU_MEM_PARITY_EN
  assign w_wword = {^w_wdata, w_wdata};
`else
  assign w_wword = w_wdata;
`endif

  // Memory array write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[w_waddr] <= w_wword;
    end
  end

  // Transfer FSM: start acceptance, word counting and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // load wins when both starts arrive together; zero length is a no-op
          if (w_start_ok && (load_start || dump_start)) begin
            r_state <= load_start ? ST_LOAD : ST_DUMP_RD;
            r_base  <= xfer_base;
            r_len   <= xfer_len;
            r_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_last) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DUMP_RD: begin
          r_state <= ST_DUMP_OUT;
        end
        ST_DUMP_OUT: begin
          if (dump_ready) begin
            r_cnt   <= r_cnt + CNT_ONE;
            r_state <= w_last ? ST_IDLE : ST_DUMP_RD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // CPU read port: read-first, one-cycle latency, frozen outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rdata <= '0;
    end else if (w_idle) begin
      r_cpu_rdata <= mem[cpu_addr][DATA_W-1:0];
    end
  end

  // Dump data register: loaded in DUMP_RD, held through DUMP_OUT stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dump_data <= '0;
    end else if (r_state == ST_DUMP_RD) begin
      r_dump_data <= mem[w_xfer_addr][DATA_W-1:0];
    end
  end

`ifdef VSCPU_MEM_PARITY_EN
  logic r_parity_err;

  // Sticky parity flag: a stored word whose bits do not XOR to zero is bad.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_idle && (^mem[cpu_addr])) begin
      r_parity_err <= 1'b1;
    end else if ((r_state == ST_DUMP_RD) && (^mem[w_xfer_addr])) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign cpu_rdata  = r_cpu_rdata;
  assign dump_data  = r_dump_data;
  assign busy       = !w_idle;
  assign cpu_hold   = !w_idle;
  assign load_ready = (r_state == ST_LOAD);
  assign dump_valid = (r_state == ST_DUMP_OUT);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_vscpu_mem_responder.sv
// Testbench for vscpu_mem_responder (default build; the parity block is only
// exercised when VSCPU_MEM_PARITY_EN is defined).
// Drivers push expected CPU-read and dump words into queues; monitors on the
// falling edge pop and compare whenever the DUT presents data.

module tb_vscpu_mem_responder;

  localparam int ADDR_LEN = 14;
  localparam int DATA_W   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ADDR_LEN-1:0] cpu_addr;
  logic                cpu_wrEn;
  logic [DATA_W-1:0]   cpu_wdata;
  logic [DATA_W-1:0]   cpu_rdata;
  logic                cpu_hold;
  logic [ADDR_LEN-1:0] xfer_base;
  logic [ADDR_LEN:0]   xfer_len;
  logic                load_start;
  logic                load_valid;
  logic [DATA_W-1:0]   load_data;
  logic                load_ready;
  logic                dump_start;
  logic                dump_valid;
  logic [DATA_W-1:0]   dump_data;
  logic                dump_ready;
  logic                busy;
  logic                parity_err;
  logic [1:0]          dbg_state;

  vscpu_mem_responder #(
    .ADDR_LEN(ADDR_LEN),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wrEn  (cpu_wrEn),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_hold  (cpu_hold),
    .xfer_base (xfer_base),
    .xfer_len  (xfer_len),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .dump_start(dump_start),
    .dump_valid(dump_valid),
    .dump_data (dump_data),
    .dump_ready(dump_ready),
    .busy      (busy),
    .parity_err(parity_err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] rd_exp_q[$];
  logic [DATA_W-1:0] dump_exp_q[$];
  logic [DATA_W-1:0] load_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;
  logic [DATA_W-1:0] mon_exp;
  bit prev_stall = 1'b0;
  bit prev_rst = 1'b0;

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    if (rd_req_d) begin
      if (rd_exp_q.size() == 0) begin
        check("cpu_rdata_unexpected", 32'd1, 32'd0);
      end else begin
        mon_exp = rd_exp_q.pop_front();
        check("cpu_rdata", cpu_rdata, mon_exp);
      end
    end
    if (dump_valid) begin
      if (dump_exp_q.size() == 0) begin
        check("dump_unexpected", 32'd1, 32'd0);
      end else begin
        check("dump_data", dump_data, dump_exp_q[0]);
        if (dump_ready) mon_exp = dump_exp_q.pop_front();
      end
    end
    if (prev_stall && !rst && !prev_rst) begin
      check("dump_valid_held", dump_valid, 1'b1);
    end
    prev_stall = dump_valid && !dump_ready;
    prev_rst   = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR_LEN-1:0] a, input logic [DATA_W-1:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_wrEn = 1'b1;
    tick();
    cpu_wrEn = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_LEN-1:0] a, input logic [DATA_W-1:0] exp);
    cpu_addr = a; rd_req = 1'b1;
    rd_exp_q.push_back(exp);
    tick();
    rd_req = 1'b0;
  endtask

  // Streams load_q into memory; with gaps, an idle cycle precedes every word
  // and the first gap also attempts a CPU write to address 50.
  task automatic load_xfer(input logic [ADDR_LEN-1:0] base, input logic [ADDR_LEN:0] len,
                           input bit gaps);
    xfer_base = base; xfer_len = len; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_ready_after_start", load_ready, 1'b1);
    for (int k = 0; k < int'(len); k++) begin
      if (gaps) begin
        load_valid = 1'b0;
        if (k == 0) begin
          cpu_addr = 14'd50; cpu_wdata = 32'h55; cpu_wrEn = 1'b1;
        end
        tick();
        cpu_wrEn = 1'b0;
        check("cpu_hold_during_load", cpu_hold, 1'b1);
      end
      load_valid = 1'b1;
      load_data  = load_q.pop_front();
      tick();
    end
    load_valid = 1'b0;
    check("load_ready_after_last", load_ready, 1'b0);
    check("cpu_hold_after_last", cpu_hold, 1'b0);
  endtask

  // Drains a dump; word stall_idx is held off for stall_n cycles.
  task automatic dump_xfer(input logic [ADDR_LEN-1:0] base, input logic [ADDR_LEN:0] len,
                           input int stall_idx, input int stall_n);
    int waited;
    xfer_base = base; xfer_len = len; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("dump_rd_first_cycle", dump_valid, 1'b0);
    check("busy_in_dump", busy, 1'b1);
    for (int k = 0; k < int'(len); k++) begin
      waited = 0;
      while (!dump_valid && waited < 10) begin
        tick();
        waited++;
      end
      check("dump_valid_latency", waited, 1);
      if (k == stall_idx) repeat (stall_n) tick();
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
      check("dump_bubble", dump_valid, 1'b0);
    end
    check("busy_after_dump", busy, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    rst = 1'b1;
    cpu_addr = '0; cpu_wrEn = 1'b0; cpu_wdata = '0;
    xfer_base = '0; xfer_len = '0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_dump_valid", dump_valid, 1'b0);
    check("rst_dump_data", dump_data, 32'h0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick();

    // CPU port basics
    cpu_write(14'd5, 32'hDEADBEEF);
    cpu_read(14'd5, 32'hDEADBEEF);
    cpu_write(14'd6, 32'h11);
    cpu_addr = 14'd6; cpu_wdata = 32'h22; cpu_wrEn = 1'b1; rd_req = 1'b1;
    rd_exp_q.push_back(32'h11);            // read-first on collision
    tick();
    cpu_wrEn = 1'b0; rd_req = 1'b0;
    cpu_read(14'd6, 32'h22);
    cpu_write(14'd50, 32'h77);

    // load with gaps, CPU write attempted mid-load must be dropped
    load_q = '{32'hA, 32'hB, 32'hC};
    load_xfer(14'd100, 15'd3, 1'b1);
    cpu_read(14'd50, 32'h77);
    cpu_read(14'd100, 32'hA);
    cpu_read(14'd101, 32'hB);
    cpu_read(14'd102, 32'hC);

    // dump with 4 cycles of backpressure on word 1
    dump_exp_q.push_back(32'hA);
    dump_exp_q.push_back(32'hB);
    dump_exp_q.push_back(32'hC);
    dump_xfer(14'd100, 15'd3, 1, 4);

    // wrap-around load
    load_q = '{32'h1111, 32'h2222};
    load_xfer(14'd16383, 15'd2, 1'b0);
    cpu_read(14'd16383, 32'h1111);
    cpu_read(14'd0, 32'h2222);

    // zero-length starts are ignored
    xfer_base = 14'd300; xfer_len = 15'd0; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("len0_load_busy", busy, 1'b0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("len0_dump_busy", busy, 1'b0);
    tick();
    check("len0_dump_valid", dump_valid, 1'b0);

    // simultaneous starts: load wins
    xfer_base = 14'd200; xfer_len = 15'd1; load_start = 1'b1; dump_start = 1'b1;
    tick();
    load_start = 1'b0; dump_start = 1'b0;
    check("both_start_state", dbg_state, 2'd1);
    check("both_start_load_ready", load_ready, 1'b1);
    load_valid = 1'b1; load_data = 32'h33;
    tick();
    load_valid = 1'b0;
    check("both_start_done_busy", busy, 1'b0);
    check("both_start_no_dump", dump_valid, 1'b0);
    cpu_read(14'd200, 32'h33);

    // reset in the middle of a dump
    dump_exp_q.push_back(32'hA);
    xfer_base = 14'd100; xfer_len = 15'd3; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    waited = 0;
    while (!dump_valid && waited < 10) begin
      tick();
      waited++;
    end
    check("middump_valid_up", dump_valid, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("middump_rst_valid", dump_valid, 1'b0);
    check("middump_rst_busy", busy, 1'b0);
    rst = 1'b0;
    dump_exp_q.delete();
    tick();
    cpu_read(14'd100, 32'hA);
    cpu_read(14'd101, 32'hB);
    cpu_read(14'd102, 32'hC);

`ifdef VSCPU_MEM_PARITY_EN
    check("parity_clean", parity_err, 1'b0);
    cpu_write(14'd7, 32'h0F);
    dut.mem[7][0] = ~dut.mem[7][0];
    cpu_read(14'd7, 32'h0E);
    check("parity_set", parity_err, 1'b1);
    repeat (3) tick();
    check("parity_sticky", parity_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("parity_cleared", parity_err, 1'b0);
`else
    check("parity_tied_low", parity_err, 1'b0);
`endif

    repeat (3) tick();
    check("rd_queue_drained", rd_exp_q.size(), 0);
    check("dump_queue_drained", dump_exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
